puf_crp_sequencer: RTL and testbench
====================================

# puf_crp_sequencer

Hardware challenge–response sequencer that sits directly upstream of the arbiter PUF `delay_line`. It generates challenges with a 64-bit LFSR and fires the `launch` pulse into the delay line. It samples the arbiter `response` several times per challenge and majority-votes the samples. Each resulting challenge/response pair is streamed over a valid/ready interface to the downstream logger or UART.

## Interface
- `N`, 64 — challenge width; 1..64; challenge = `lfsr[N-1:0]`
- `REPEATS`, 5 — launches per challenge; odd, ≥1
- `SETTLE_CYCLES`, 8 — cycles waited after launch before sampling; ≥2
- `LFSR_SEED`, 64'h1 — LFSR load value; a value of 0 is replaced by 64'h1
- `clk` in 1 — system clock
- `rst_n` in 1 — synchronous, active-low reset
- `start` in 1 — one-cycle request to begin a run; ignored while `busy`
- `num_chal` in 16 — challenges per run; sampled when `start` is accepted
- `busy` out 1 — run in progress
- `done` out 1 — one-cycle pulse at end of run
- `launch` out 1 — to `delay_line.launch`
- `challenge` out N — to `delay_line.challenge`
- `response` in 1 — from `delay_line.response`; asynchronous, double-flop synchronised
- `m_valid` out 1 — CRP output valid
- `m_ready` in 1 — downstream accept
- `m_challenge` out N — challenge of the emitted pair
- `m_response` out 1 — majority-voted response
- `m_stable` out 1 — 1 when all REPEATS samples agreed

## Operation
- Reset values: all outputs 0, state IDLE, LFSR = seed, all counters 0.
- FSM states: IDLE → ARM → FIRE → SETTLE → SAMPLE → (ARM | EMIT) → (ARM | DONE) → IDLE.
- **IDLE:** on `start`, latch `num_chal` into `remaining`, reload the LFSR with the seed, and clear `rep_cnt` and `ones_cnt`.
  - If `num_chal` = 0, go to DONE.
  - Otherwise go to ARM.
- **ARM:** `launch` = 0 for one cycle; `challenge` already driven from the LFSR.
- **FIRE:** `launch` = 1 for exactly one cycle.
- **SETTLE:** `launch` = 0; count SETTLE_CYCLES cycles.
- **SAMPLE:** add the synchronised response to `ones_cnt` and increment `rep_cnt`.
  - If `rep_cnt` + 1 < REPEATS, go to ARM.
  - Otherwise go to EMIT.
- **EMIT:** `m_valid` = 1.
  - `m_response` = (`ones_cnt` > REPEATS/2).
  - `m_stable` = (`ones_cnt` == 0 or `ones_cnt` == REPEATS).
  - `m_challenge` = the current challenge.
  - On `m_valid && m_ready`: advance the LFSR, decrement `remaining`, and clear both counters. Go to DONE if `remaining` was 1, else go to ARM.
- **DONE:** `done` = 1 for one cycle, `busy` = 0 from the next cycle, return to IDLE.
- **LFSR:** next = {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}. The first challenge of every run equals the seed.
- **Stability:** `challenge` is stable from ARM of the first repeat through the EMIT handshake of that challenge.
- **Counter widths:** `rep_cnt` and `ones_cnt` are $clog2(REPEATS+1) bits; the settle counter is $clog2(SETTLE_CYCLES+1) bits; `remaining` is 16 bits.

## Timing
- `start` is sampled in cycle 0; `busy` = 1 from cycle 1.
- One repeat lasts SETTLE_CYCLES+3 cycles: ARM 1, FIRE 1, SETTLE SETTLE_CYCLES, SAMPLE 1.
- The first `m_valid` is asserted in cycle REPEATS·(SETTLE_CYCLES+3)+1; with defaults this is cycle 56.
- Backpressure: while `m_ready` = 0, the payload is held and no launch occurs.
- The next ARM follows the handshake cycle directly.
- `done` is asserted in the cycle after the last handshake.
- `start` while `busy` is ignored and has no side effects.
- `rst_n` low mid-run: on the next edge, return to reset values. `m_valid` drops and no `done` is issued.
- The synchroniser adds 2 cycles of latency. SETTLE_CYCLES ≥ 2 guarantees the sampled value reflects the current launch; this is enforced by an elaboration assertion.

## Structure
- `puf_pkg`:
  - state enum `crp_state_t`;
  - LFSR tap constant and `lfsr64_next()` function;
  - default seed constant.
- Sub-module `puf_lfsr64`, with ports `clk`, `rst_n`, `load`, `advance`, `seed`, `q[63:0]`. The remaining FSM, counters and synchroniser live in `puf_crp_sequencer`.

## Test plan
1. **LFSR sequence:** defaults, `num_chal` = 3, response tied to 1, `m_ready` = 1.
   - Expect `m_challenge` = 0x1, 0x2, 0x4, each with `m_response` = 1 and `m_stable` = 1.
   - Expect the first `m_valid` in cycle 56 and `done` once.
2. **Majority vote:** the bench drives response per launch as 1, 1, 0, 1, 1.
   - Expect `m_response` = 1 and `m_stable` = 0.
   - The pattern 0, 1, 0, 0, 1 gives `m_response` = 0 and `m_stable` = 0.
3. **Backpressure:** hold `m_ready` = 0 for 20 cycles during EMIT.
   - Expect payload and `challenge` unchanged, `launch` stays 0, and the next FIRE starts 2 cycles after the handshake.
4. **Empty run:** `num_chal` = 0.
   - Expect `done` pulse in cycle 1, no `launch`, no `m_valid`.
   - A `start` pulsed mid-run has no effect on the count or the sequence.
5. **Reset mid-run:** assert `rst_n` = 0 during SETTLE of challenge 2.
   - Expect all outputs 0 next cycle.
   - A subsequent `start` emits first challenge 0x1 again.
6. **Launch shape:** check every FIRE.
   - `launch` is high for exactly 1 cycle and is preceded by at least 1 low cycle.
   - Exactly REPEATS launches occur per emitted pair.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and LFSR helpers for the arbiter-PUF challenge/response sequencer.
// Imported by the LFSR sub-module and the sequencer top.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } crp_state_t;

    // Feedback taps at bits 63, 62, 60 and 59.
    localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'h1;

    function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock the LFSR, so it is never loaded.
    function automatic logic [63:0] lfsr64_seed_fix(input logic [63:0] s);
        return (s == 64'h0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Valid/ready stream carrying one challenge/response pair per transfer.
// The sequencer drives the master side; the logger or UART sits on the slave side.
interface puf_crp_if #(
    parameter int N = 64
);
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_challenge;
    logic         m_response;
    logic         m_stable;

    modport master (
        output m_valid,
        output m_challenge,
        output m_response,
        output m_stable,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_challenge,
        input  m_response,
        input  m_stable,
        output m_ready
    );
endinterface

// File: rtl/puf_lfsr64.sv
// 64-bit Fibonacci LFSR that generates PUF challenges.
// A load restarts the sequence at the seed; advance steps it once.
module puf_lfsr64
    import puf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [63:0] seed,
    output logic [63:0] q
);

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values, which keeps simulation consistent with the synthesised netlist.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= lfsr64_seed_fix(seed);
        end else if (load) begin
            q <= lfsr64_seed_fix(seed);
        end else if (advance) begin
            q <= lfsr64_next(q);
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Launches LFSR challenges into the arbiter-PUF delay line, majority-votes REPEATS
// synchronised response samples per challenge and streams out each CRP.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int          N             = 64,
    parameter int          REPEATS       = 5,
    parameter int          SETTLE_CYCLES = 8,
    parameter logic [63:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   num_chal,
    output logic          busy,
    output logic          done,
    output logic          launch,
    output logic [N-1:0]  challenge,
    input  logic          response,
    puf_crp_if.master     crp
);

    localparam int CW = $clog2(REPEATS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    // The two-flop synchroniser must settle inside the wait after each launch.
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("puf_crp_sequencer: SETTLE_CYCLES must be >= 2");
    end
    if (REPEATS < 1 || (REPEATS % 2) == 0) begin : g_bad_repeats
        $error("puf_crp_sequencer: REPEATS must be odd and >= 1");
    end
    if (N < 1 || N > 64) begin : g_bad_width
        $error("puf_crp_sequencer: N must be in 1..64");
    end

    crp_state_t    state, state_next;
    logic [15:0]   remaining;
    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] ones_cnt;
    logic [SW-1:0] settle_cnt;
    logic          resp_meta, resp_sync;
    logic          lfsr_load, lfsr_advance;
    logic [63:0]   lfsr_q;
    logic          chal_active;

    puf_lfsr64 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load  = 1'b1;
                    state_next = (num_chal == 16'd0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM:    state_next = ST_FIRE;
            ST_FIRE:   state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: state_next = (int'(rep_cnt) + 1 < REPEATS) ? ST_ARM : ST_EMIT;
            ST_EMIT: begin
                if (crp.m_ready) begin
                    lfsr_advance = 1'b1;
                    state_next   = (remaining == 16'd1) ? ST_DONE : ST_ARM;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            rep_cnt    <= '0;
            ones_cnt   <= '0;
            settle_cnt <= '0;
            resp_meta  <= 1'b0;
            resp_sync  <= 1'b0;
        end else begin
            state     <= state_next;
            resp_meta <= response;
            resp_sync <= resp_meta;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= num_chal;
                        rep_cnt   <= '0;
                        ones_cnt  <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= (state_next == ST_SAMPLE) ? '0 : settle_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    ones_cnt <= ones_cnt + CW'(resp_sync);
                    rep_cnt  <= rep_cnt + 1'b1;
                end
                ST_EMIT: begin
                    if (crp.m_ready) begin
                        remaining <= remaining - 16'd1;
                        rep_cnt   <= '0;
                        ones_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Challenge outputs are gated so they read zero outside an active challenge.
    assign chal_active = (state == ST_ARM)    || (state == ST_FIRE) ||
                         (state == ST_SETTLE) || (state == ST_SAMPLE) ||
                         (state == ST_EMIT);

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign launch    = (state == ST_FIRE);
    assign challenge = chal_active ? lfsr_q[N-1:0] : '0;

    assign crp.m_valid     = (state == ST_EMIT);
    assign crp.m_challenge = crp.m_valid ? lfsr_q[N-1:0] : '0;
    assign crp.m_response  = crp.m_valid && (int'(ones_cnt) > REPEATS / 2);
    assign crp.m_stable    = crp.m_valid && (ones_cnt == '0 || int'(ones_cnt) == REPEATS);

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Scoreboard bench for puf_crp_sequencer: a responder models the PUF per launch and
// queues expected CRPs; a monitor checks every handshake and the launch/EMIT timing.
module tb_puf_crp_sequencer;
    localparam int N       = 64;
    localparam int REPEATS = 5;
    localparam int SETTLE  = 8;
    localparam logic [63:0] SEED = 64'h1;

    typedef struct {
        logic [63:0] chal;
        logic        resp;
        logic        stable;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  num_chal = '0;
    logic         response = 1'b0;
    logic         busy, done, launch;
    logic [N-1:0] challenge;

    puf_crp_if #(.N(N)) crp ();

    puf_crp_sequencer #(
        .N(N), .REPEATS(REPEATS), .SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_chal(num_chal),
        .busy(busy), .done(done), .launch(launch), .challenge(challenge),
        .response(response), .crp(crp.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_count = 0;
    int launches_total = 0;
    int launches_since_emit = 0;
    int emits_total = 0;
    bit rand_ready = 1'b0;
    bit prev_launch = 1'b0;

    // Reference model state: challenge sequence and per-challenge vote tally.
    logic [63:0] model_lfsr;
    int          group_launches;
    int          group_ones;
    exp_t        exp_q[$];
    bit          forced_bits[$];
    logic [63:0] emitted_chal[$];
    bit          emitted_resp[$];
    bit          emitted_stable[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Challenge sequence derived straight from the recurrence definition.
    function automatic logic [63:0] model_step(input logic [63:0] s);
        logic fb;
        fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return (s << 1) | {63'b0, fb};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rand_ready) crp.m_ready = 1'($urandom_range(0, 1));

    // Responder: behaves as the delay line, picking one response bit per launch.
    always @(negedge clk) begin
        if (launch) begin
            bit b;
            check("launch_single_cycle", 64'(prev_launch), 64'd0);
            check("launch_challenge", challenge, model_lfsr);
            b = (forced_bits.size() > 0) ? forced_bits.pop_front() : 1'($urandom_range(0, 1));
            response = b;
            launches_total++;
            launches_since_emit++;
            group_launches++;
            group_ones += int'(b);
            if (group_launches == REPEATS) begin
                exp_t e;
                e.chal   = model_lfsr;
                e.resp   = (group_ones * 2 > REPEATS);
                e.stable = (group_ones == 0) || (group_ones == REPEATS);
                exp_q.push_back(e);
                model_lfsr     = model_step(model_lfsr);
                group_launches = 0;
                group_ones     = 0;
            end
        end
        prev_launch = launch;
    end

    // Monitor: compares every accepted pair against the scoreboard.
    always @(negedge clk) begin
        if (done) done_count++;
        if (crp.m_valid) begin
            check("no_launch_in_emit", 64'(launch), 64'd0);
            check("challenge_stable_emit", challenge, crp.m_challenge);
            if (crp.m_ready) begin
                emitted_chal.push_back(crp.m_challenge);
                emitted_resp.push_back(crp.m_response);
                emitted_stable.push_back(crp.m_stable);
                emits_total++;
                check("launches_per_pair", launches_since_emit, REPEATS);
                launches_since_emit = 0;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pair", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_challenge", crp.m_challenge, e.chal);
                    check("m_response", 64'(crp.m_response), 64'(e.resp));
                    check("m_stable", 64'(crp.m_stable), 64'(e.stable));
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"},
              64'({busy, done, launch, crp.m_valid, crp.m_response, crp.m_stable}), 64'd0);
        check({name, "_challenge"}, challenge, 64'd0);
        check({name, "_m_challenge"}, crp.m_challenge, 64'd0);
    endtask

    task automatic clear_emitted();
        emitted_chal.delete();
        emitted_resp.delete();
        emitted_stable.delete();
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        model_lfsr     = SEED;
        group_launches = 0;
        group_ones     = 0;
        num_chal  = 16'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!crp.m_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!crp.m_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_launch(input int budget);
        int n = 0;
        while (!launch && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!launch) check("launch_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int d0, l0, e0, hs_cyc;
        logic [63:0] held_chal;
        logic        held_resp, held_stable;

        crp.m_ready = 1'b1;
        model_lfsr = SEED;
        group_launches = 0;
        group_ones = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // LFSR sequence with all-ones responses and first-valid latency.
        clear_emitted();
        d0 = done_count;
        repeat (3 * REPEATS) forced_bits.push_back(1'b1);
        start_run(3);
        wait_valid(200);
        check("first_valid_cycle", cyc - start_cyc, REPEATS * (SETTLE + 3) + 1);
        wait_done(600);
        check("t1_done_once", done_count - d0, 1);
        check("t1_pairs", emitted_chal.size(), 3);
        if (emitted_chal.size() == 3) begin
            check("t1_chal0", emitted_chal[0], 64'h1);
            check("t1_chal1", emitted_chal[1], 64'h2);
            check("t1_chal2", emitted_chal[2], 64'h4);
            check("t1_resp_stable", 64'({emitted_resp[2], emitted_stable[2]}), 64'b11);
        end

        // Majority vote with split patterns.
        clear_emitted();
        forced_bits = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 1};
        start_run(2);
        wait_done(600);
        check("t2_pairs", emitted_resp.size(), 2);
        if (emitted_resp.size() == 2) begin
            check("t2_first", 64'({emitted_resp[0], emitted_stable[0]}), 64'b10);
            check("t2_second", 64'({emitted_resp[1], emitted_stable[1]}), 64'b00);
        end

        // Backpressure: payload held, no launch, next FIRE two cycles after handshake.
        crp.m_ready = 1'b0;
        start_run(2);
        wait_valid(200);
        held_chal   = crp.m_challenge;
        held_resp   = crp.m_response;
        held_stable = crp.m_stable;
        repeat (20) begin
            @(negedge clk);
            check("bp_hold", {crp.m_challenge}, held_chal);
            check("bp_hold_flags", 64'({crp.m_valid, crp.m_response, crp.m_stable, launch}),
                  64'({1'b1, held_resp, held_stable, 1'b0}));
            check("bp_challenge", challenge, held_chal);
        end
        crp.m_ready = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        wait_launch(20);
        check("bp_fire_gap", cyc - hs_cyc, 2);
        wait_done(600);

        // Empty run: done in cycle 1, nothing launched or emitted.
        l0 = launches_total;
        e0 = emits_total;
        d0 = done_count;
        start_run(0);
        check("empty_done_cycle1", 64'(done), 64'd1);
        repeat (5) @(negedge clk);
        check("empty_no_launch", launches_total - l0, 0);
        check("empty_no_valid", emits_total - e0, 0);
        check("empty_done_once", done_count - d0, 1);
        check("empty_idle", 64'(busy), 64'd0);

        // A start while busy must not disturb count or sequence.
        e0 = emits_total;
        start_run(3);
        repeat (70) @(negedge clk);
        num_chal = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(800);
        check("busy_start_pairs", emits_total - e0, 3);

        // Reset during SETTLE of challenge 2.
        d0 = done_count;
        e0 = emits_total;
        start_run(3);
        while (emits_total == e0 && cyc - start_cyc < 300) @(negedge clk);
        wait_launch(20);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        exp_q.delete();
        launches_since_emit = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_no_done", done_count - d0, 0);
        clear_emitted();
        start_run(1);
        wait_done(300);
        check("reset_restart_pairs", emitted_chal.size(), 1);
        if (emitted_chal.size() == 1) check("reset_restart_chal", emitted_chal[0], 64'h1);

        // Randomised runs with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            e0 = emits_total;
            start_run($urandom_range(1, 4));
            wait_done(2000);
            check("rand_pairs", emits_total - e0, int'(num_chal));
        end
        rand_ready = 1'b0;
        crp.m_ready = 1'b1;

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
